// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared forwarding-select codes, register names and scoreboard slot type
package mips_pipe_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;
  typedef struct packed {
    logic       valid;
    logic       wr_en;
    logic [4:0] dest;
    logic       is_load;
  } sb_slot_t;
endpackage

// File: rtl/hazard_slot.sv
// hazard_slot: one scoreboard stage register with load/hold/bubble and async clear
module hazard_slot
  import mips_pipe_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_load,
  input  logic     i_bubble,
  input  sb_slot_t i_d,
  output sb_slot_t o_q
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_q <= '0;
    else if (i_load) o_q <= i_bubble ? '0 : i_d;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand-forward selects and load-use stall; FWD_HAZARD_STATS_EN adds stall/forward counters
module fwd_hazard_unit
  import mips_pipe_pkg::*;
#(
  parameter int NB_ADDR = 5,
  parameter int NB_FWD  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_halt,
  input  logic               i_flush,
  input  logic               i_id_valid,
  input  logic [NB_ADDR-1:0] i_id_rs,
  input  logic [NB_ADDR-1:0] i_id_rt,
  input  logic               i_id_uses_rt,
  input  logic               i_id_wr_en,
  input  logic [NB_ADDR-1:0] i_id_dest,
  input  logic               i_id_mem_read,
  output logic [NB_FWD-1:0]  o_forwardA,
  output logic [NB_FWD-1:0]  o_forwardB,
  output logic               o_stall
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]        o_stall_count,
  output logic [31:0]        o_fwd_count
`endif
);
  sb_slot_t ex_q, mem_q, wb_q, ex_d;
  logic ex_wr, mem_wr, haz, bubble;
  logic [NB_FWD-1:0] fwd_a_nx, fwd_b_nx;
  logic unused_wb;
  assign unused_wb = ^{wb_q, REG_RA};
  assign ex_wr  = ex_q.valid && ex_q.wr_en && ex_q.dest != REG_ZERO;
  assign mem_wr = mem_q.valid && mem_q.wr_en && mem_q.dest != REG_ZERO;
  assign haz = ex_wr && ex_q.is_load && i_id_valid &&
               (ex_q.dest == i_id_rs || (i_id_uses_rt && ex_q.dest == i_id_rt));
  assign o_stall = haz && !i_flush && !i_halt;
  assign bubble  = o_stall || i_flush || !i_id_valid;
  assign ex_d = '{valid: 1'b1, wr_en: i_id_wr_en, dest: i_id_dest, is_load: i_id_mem_read};
  // EX beats MEM so the youngest producer wins
  always_comb begin
    fwd_a_nx = (ex_wr && ex_q.dest == i_id_rs) ? FWD_MEM :
               (mem_wr && mem_q.dest == i_id_rs) ? FWD_WB : FWD_RF;
    fwd_b_nx = !i_id_uses_rt ? FWD_RF :
               (ex_wr && ex_q.dest == i_id_rt) ? FWD_MEM :
               (mem_wr && mem_q.dest == i_id_rt) ? FWD_WB : FWD_RF;
  end
  hazard_slot u_ex  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(!i_halt), .i_bubble(bubble), .i_d(ex_d),  .o_q(ex_q));
  hazard_slot u_mem (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(!i_halt), .i_bubble(1'b0),   .i_d(ex_q),  .o_q(mem_q));
  hazard_slot u_wb  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(!i_halt), .i_bubble(1'b0),   .i_d(mem_q), .o_q(wb_q));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_forwardA <= FWD_RF;
      o_forwardB <= FWD_RF;
    end else if (!i_halt) begin
      o_forwardA <= bubble ? FWD_RF : fwd_a_nx;
      o_forwardB <= bubble ? FWD_RF : fwd_b_nx;
    end
`ifdef FWD_HAZARD_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_stall_count <= '0;
      o_fwd_count   <= '0;
    end else if (!i_halt) begin
      if (o_stall && o_stall_count != '1) o_stall_count <= o_stall_count + 32'd1;
      if (!bubble && (fwd_a_nx != FWD_RF || fwd_b_nx != FWD_RF) && o_fwd_count != '1)
        o_fwd_count <= o_fwd_count + 32'd1;
    end
`endif
endmodule
